id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard detection,
//            write-back bypass on operand capture and a saturating bubble count.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [7:0]       ctrl_i,
  input  logic [31:0]      RSdata_i,
  input  logic [31:0]      RTdata_i,
  input  logic [31:0]      imm_i,
  input  logic [4:0]       RSaddr_i,
  input  logic [4:0]       RTaddr_i,
  input  logic [4:0]       RDaddr_i,
  input  logic             WB_RegWrite_i,
  input  logic [4:0]       WB_RegAddr_i,
  input  logic [31:0]      WB_data_i,
  output logic             valid_o,
  output logic [7:0]       ctrl_o,
  output logic [31:0]      RSdata_o,
  output logic [31:0]      RTdata_o,
  output logic [31:0]      imm_o,
  output logic [4:0]       RSaddr_o,
  output logic [4:0]       RTaddr_o,
  output logic [4:0]       RDaddr_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [1:0]       ACT_LOAD   = 2'd0;
  localparam logic [1:0]       ACT_HOLD   = 2'd1;
  localparam logic [1:0]       ACT_BUBBLE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             valid_q,    valid_d;
  logic [7:0]       ctrl_q,     ctrl_d;
  logic [31:0]      rs_data_q,  rs_data_d;
  logic [31:0]      rt_data_q,  rt_data_d;
  logic [31:0]      imm_q,      imm_d;
  logic [4:0]       rs_addr_q,  rs_addr_d;
  logic [4:0]       rt_addr_q,  rt_addr_d;
  logic [4:0]       rd_addr_q,  rd_addr_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic [1:0]  w_act;
  logic        w_hazard;
  logic        w_rs_byp;
  logic        w_rt_byp;
  logic        w_rt_match;

  // A load in EX whose destination is read by the instruction in ID.
  assign w_rt_match = (rt_addr_q == RSaddr_i) | (rt_addr_q == RTaddr_i);
  assign w_hazard   = valid_q & ctrl_q[5] & (rt_addr_q != 5'd0) & valid_i & w_rt_match;

  // Register 0 is hard-wired zero, so it is never bypassed.
  assign w_rs_byp = WB_RegWrite_i & (WB_RegAddr_i != 5'd0) & (WB_RegAddr_i == RSaddr_i);
  assign w_rt_byp = WB_RegWrite_i & (WB_RegAddr_i != 5'd0) & (WB_RegAddr_i == RTaddr_i);

  always_comb begin
    w_act = ACT_LOAD;
    if (stall_i) begin
      w_act = ACT_HOLD;
    end else if (flush_i | w_hazard) begin
      w_act = ACT_BUBBLE;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    case (w_act)
      ACT_BUBBLE: begin
        valid_d   = 1'b0;
        ctrl_d    = 8'h00;
        rs_data_d = 32'h0;
        rt_data_d = 32'h0;
        imm_d     = 32'h0;
        rs_addr_d = 5'd0;
        rt_addr_d = 5'd0;
        rd_addr_d = 5'd0;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end
      ACT_LOAD: begin
        valid_d   = valid_i;
        ctrl_d    = ctrl_i;
        rs_data_d = w_rs_byp ? WB_data_i : RSdata_i;
        rt_data_d = w_rt_byp ? WB_data_i : RTdata_i;
        imm_d     = imm_i;
        rs_addr_d = RSaddr_i;
        rt_addr_d = RTaddr_i;
        rd_addr_d = RDaddr_i;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      ctrl_q    <= 8'h00;
      rs_data_q <= 32'h0;
      rt_data_q <= 32'h0;
      imm_q     <= 32'h0;
      rs_addr_q <= 5'd0;
      rt_addr_q <= 5'd0;
      rd_addr_q <= 5'd0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign ctrl_o       = ctrl_q;
  assign RSdata_o     = rs_data_q;
  assign RTdata_o     = rt_data_q;
  assign imm_o        = imm_q;
  assign RSaddr_o     = rs_addr_q;
  assign RTaddr_o     = rt_addr_q;
  assign RDaddr_o     = rd_addr_q;
  assign hazard_o     = w_hazard;
  assign bubble_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Scoreboard bench for id_ex_stage (default and 2-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int OBS_W = 139;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i, stall_i, flush_i, valid_i, WB_RegWrite_i;
  logic [7:0]  ctrl_i;
  logic [31:0] RSdata_i, RTdata_i, imm_i, WB_data_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i, WB_RegAddr_i;

  logic        valid_o, hazard_o;
  logic [7:0]  ctrl_o;
  logic [31:0] RSdata_o, RTdata_o, imm_o;
  logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o;
  logic [15:0] bubble_cnt_o;

  logic        s_valid_o, s_hazard_o;
  logic [7:0]  s_ctrl_o;
  logic [31:0] s_RSdata_o, s_RTdata_o, s_imm_o;
  logic [4:0]  s_RSaddr_o, s_RTaddr_o, s_RDaddr_o;
  logic [1:0]  s_bubble_cnt_o;

  id_ex_stage u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .ctrl_i(ctrl_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i),
    .imm_i(imm_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .WB_RegWrite_i(WB_RegWrite_i), .WB_RegAddr_i(WB_RegAddr_i), .WB_data_i(WB_data_i),
    .valid_o(valid_o), .ctrl_o(ctrl_o), .RSdata_o(RSdata_o), .RTdata_o(RTdata_o),
    .imm_o(imm_o), .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .RDaddr_o(RDaddr_o),
    .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_stage #(.CNT_W(2)) u_dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .ctrl_i(ctrl_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i),
    .imm_i(imm_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .WB_RegWrite_i(WB_RegWrite_i), .WB_RegAddr_i(WB_RegAddr_i), .WB_data_i(WB_data_i),
    .valid_o(s_valid_o), .ctrl_o(s_ctrl_o), .RSdata_o(s_RSdata_o), .RTdata_o(s_RTdata_o),
    .imm_o(s_imm_o), .RSaddr_o(s_RSaddr_o), .RTaddr_o(s_RTaddr_o), .RDaddr_o(s_RDaddr_o),
    .hazard_o(s_hazard_o), .bubble_cnt_o(s_bubble_cnt_o)
  );

  // Both instances must agree on everything except the counter width.
  logic [OBS_W-1:0] w_obs;
  assign w_obs = {valid_o, ctrl_o, RSdata_o, RTdata_o, imm_o, RSaddr_o, RTaddr_o, RDaddr_o,
                  bubble_cnt_o, s_valid_o, s_bubble_cnt_o};
  logic w_sat_same;
  assign w_sat_same = ({s_ctrl_o, s_RSdata_o, s_RTdata_o, s_imm_o, s_RSaddr_o, s_RTaddr_o,
                        s_RDaddr_o, s_hazard_o} ===
                       {ctrl_o, RSdata_o, RTdata_o, imm_o, RSaddr_o, RTaddr_o, RDaddr_o, hazard_o});

  int checks = 0;
  int failures = 0;

  logic             m_valid;
  logic [7:0]       m_ctrl;
  logic [31:0]      m_rsd, m_rtd, m_imm;
  logic [4:0]       m_rsa, m_rta, m_rda;
  logic [15:0]      m_cnt;
  logic [1:0]       m_cnt2;
  logic [OBS_W-1:0] sb[$];
  logic [OBS_W-1:0] exp_obs;

  function automatic logic m_hazard();
    return m_valid & m_ctrl[5] & (m_rta != 5'd0) & valid_i &
           ((m_rta == RSaddr_i) | (m_rta == RTaddr_i));
  endfunction

  task automatic m_bubble();
    m_valid = 1'b0; m_ctrl = 8'h00; m_rsd = 32'h0; m_rtd = 32'h0; m_imm = 32'h0;
    m_rsa = 5'd0; m_rta = 5'd0; m_rda = 5'd0;
  endtask

  // Advance the model by one edge, queue its expected outputs, then clock the DUT.
  task automatic cycle();
    logic hz;
    hz = m_hazard();
    if (rst_i) begin
      m_bubble(); m_cnt = '0; m_cnt2 = '0;
    end else if (stall_i) begin
    end else if (flush_i || hz) begin
      m_bubble();
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
    end else begin
      m_valid = valid_i; m_ctrl = ctrl_i; m_imm = imm_i;
      m_rsa = RSaddr_i; m_rta = RTaddr_i; m_rda = RDaddr_i;
      m_rsd = (WB_RegWrite_i && WB_RegAddr_i != 5'd0 && WB_RegAddr_i == RSaddr_i) ? WB_data_i : RSdata_i;
      m_rtd = (WB_RegWrite_i && WB_RegAddr_i != 5'd0 && WB_RegAddr_i == RTaddr_i) ? WB_data_i : RTdata_i;
    end
    sb.push_back({m_valid, m_ctrl, m_rsd, m_rtd, m_imm, m_rsa, m_rta, m_rda, m_cnt, m_valid, m_cnt2});
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [7:0] c, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [31:0] rsd, input logic [31:0] rtd);
    valid_i = v; ctrl_i = c; RSaddr_i = rs; RTaddr_i = rt; RSdata_i = rsd; RTdata_i = rtd;
    RDaddr_i = rt + 5'd1; imm_i = {27'h7FFFFFF, rs};
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    cycle();
    stall_i = 1'b0; flush_i = 1'b0;
    cycle();
    for (int i = 0; i < 2; i++) begin
      exp_obs = sb.pop_front(); checks++;
      if (i == 1 && w_obs !== exp_obs) begin
        failures++; $display("FAIL reset_obs got=%h exp=%h", w_obs, exp_obs);
      end
    end
    checks++;
    if ({valid_o, ctrl_o, RSdata_o, bubble_cnt_o, s_bubble_cnt_o, hazard_o} !== '0) begin
      failures++; $display("FAIL reset_zero got v=%b c=%h cnt=%h hz=%b exp all 0", valid_o, ctrl_o, bubble_cnt_o, hazard_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_load();
    set_instr(1'b1, 8'h82, 5'd3, 5'd4, 32'h10, 32'h20);
    cycle();
    exp_obs = sb.pop_front(); checks++;
    if (w_obs !== exp_obs) begin
      failures++; $display("FAIL load_obs got=%h exp=%h", w_obs, exp_obs);
    end
    checks++;
    if ({valid_o, ctrl_o, RSaddr_o, RSdata_o} !== {1'b1, 8'h82, 5'd3, 32'h10}) begin
      failures++; $display("FAIL load_fields got v=%b c=%h a=%0d d=%h exp 1 82 3 10", valid_o, ctrl_o, RSaddr_o, RSdata_o);
    end
  endtask

  task automatic test_bypass();
    logic        we  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0]  wba [4] = '{5'd5, 5'd0, 5'd6, 5'd7};
    logic [4:0]  rsa [4] = '{5'd5, 5'd0, 5'd5, 5'd7};
    logic [4:0]  rta [4] = '{5'd6, 5'd0, 5'd6, 5'd7};
    logic [31:0] rsd [4] = '{32'h0, 32'h11, 32'h33, 32'h1};
    logic [31:0] rtd [4] = '{32'h66, 32'h22, 32'h44, 32'h2};
    logic [31:0] ers [4] = '{32'hDEAD, 32'h11, 32'h33, 32'hDEAD};
    logic [31:0] ert [4] = '{32'h66, 32'h22, 32'h44, 32'hDEAD};
    WB_data_i = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      set_instr(1'b1, 8'h82, rsa[i], rta[i], rsd[i], rtd[i]);
      WB_RegWrite_i = we[i]; WB_RegAddr_i = wba[i];
      cycle();
      exp_obs = sb.pop_front(); checks++;
      if (w_obs !== exp_obs) begin
        failures++; $display("FAIL bypass_obs[%0d] got=%h exp=%h", i, w_obs, exp_obs);
      end
      checks++;
      if ({RSdata_o, RTdata_o} !== {ers[i], ert[i]}) begin
        failures++; $display("FAIL bypass_data[%0d] got rs=%h rt=%h exp rs=%h rt=%h", i, RSdata_o, RTdata_o, ers[i], ert[i]);
      end
    end
    WB_RegWrite_i = 1'b0;
  endtask

  task automatic test_load_use();
    logic [15:0] c0;
    set_instr(1'b1, 8'hE0, 5'd1, 5'd8, 32'h1, 32'h2);
    cycle();
    exp_obs = sb.pop_front();
    c0 = m_cnt;
    set_instr(1'b1, 8'h82, 5'd8, 5'd2, 32'h80, 32'h81);
    #1;
    checks++;
    if (hazard_o !== 1'b1 || s_hazard_o !== 1'b1) begin
      failures++; $display("FAIL load_use_hazard got=%b/%b exp=1", hazard_o, s_hazard_o);
    end
    cycle();
    exp_obs = sb.pop_front(); checks++;
    if (w_obs !== exp_obs || valid_o !== 1'b0 || hazard_o !== 1'b0 || bubble_cnt_o !== c0 + 16'd1) begin
      failures++; $display("FAIL load_use_bubble got v=%b hz=%b cnt=%0d exp v=0 hz=0 cnt=%0d", valid_o, hazard_o, bubble_cnt_o, c0 + 16'd1);
    end
    cycle();
    exp_obs = sb.pop_front(); checks++;
    if (w_obs !== exp_obs || valid_o !== 1'b1 || RSaddr_o !== 5'd8) begin
      failures++; $display("FAIL load_use_reload got v=%b rs=%0d exp v=1 rs=8", valid_o, RSaddr_o);
    end
  endtask

  task automatic test_stall_flush();
    logic [15:0] c0;
    set_instr(1'b1, 8'h82, 5'd3, 5'd4, 32'h10, 32'h20);
    cycle();
    exp_obs = sb.pop_front();
    c0 = m_cnt;
    stall_i = 1'b1; flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      exp_obs = sb.pop_front(); checks++;
      if (w_obs !== exp_obs || valid_o !== 1'b1 || bubble_cnt_o !== c0) begin
        failures++; $display("FAIL stall_freeze[%0d] got v=%b cnt=%0d exp v=1 cnt=%0d", i, valid_o, bubble_cnt_o, c0);
      end
    end
    stall_i = 1'b0;
    cycle();
    exp_obs = sb.pop_front(); checks++;
    if (w_obs !== exp_obs || valid_o !== 1'b0 || bubble_cnt_o !== c0 + 16'd1) begin
      failures++; $display("FAIL stall_release got v=%b cnt=%0d exp v=0 cnt=%0d", valid_o, bubble_cnt_o, c0 + 16'd1);
    end
    flush_i = 1'b0;
  endtask

  task automatic test_hazard_stall();
    set_instr(1'b1, 8'hE0, 5'd1, 5'd9, 32'h1, 32'h2);
    cycle();
    exp_obs = sb.pop_front();
    set_instr(1'b1, 8'h82, 5'd9, 5'd3, 32'h5, 32'h6);
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      exp_obs = sb.pop_front(); checks++;
      if (w_obs !== exp_obs || hazard_o !== 1'b1) begin
        failures++; $display("FAIL hazard_stall[%0d] got hz=%b obs=%h exp hz=1 obs=%h", i, hazard_o, w_obs, exp_obs);
      end
    end
    stall_i = 1'b0;
    cycle();
    exp_obs = sb.pop_front(); checks++;
    if (w_obs !== exp_obs || hazard_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++; $display("FAIL hazard_stall_release got hz=%b v=%b exp hz=0 v=0", hazard_o, valid_o);
    end
  endtask

  task automatic test_flush_hazard();
    logic [15:0] c0;
    set_instr(1'b1, 8'hE0, 5'd1, 5'd10, 32'h1, 32'h2);
    cycle();
    exp_obs = sb.pop_front();
    c0 = m_cnt;
    set_instr(1'b1, 8'h82, 5'd2, 5'd10, 32'h5, 32'h6);
    flush_i = 1'b1;
    cycle();
    exp_obs = sb.pop_front(); checks++;
    if (w_obs !== exp_obs || bubble_cnt_o !== c0 + 16'd1) begin
      failures++; $display("FAIL flush_hazard_once got cnt=%0d exp cnt=%0d", bubble_cnt_o, c0 + 16'd1);
    end
    flush_i = 1'b0;
  endtask

  task automatic test_saturation();
    logic [15:0] c0;
    c0 = m_cnt;
    flush_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      exp_obs = sb.pop_front();
    end
    checks++;
    if (s_bubble_cnt_o !== 2'b11 || bubble_cnt_o !== c0 + 16'd5 || w_obs !== exp_obs) begin
      failures++; $display("FAIL saturation got sat=%0d cnt=%0d exp sat=3 cnt=%0d", s_bubble_cnt_o, bubble_cnt_o, c0 + 16'd5);
    end
    flush_i = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    set_instr(1'b1, 8'hE0, 5'd1, 5'd11, 32'h1, 32'h2);
    cycle();
    exp_obs = sb.pop_front();
    set_instr(1'b1, 8'h82, 5'd11, 5'd3, 32'h7, 32'h8);
    stall_i = 1'b1; rst_i = 1'b1;
    cycle();
    exp_obs = sb.pop_front(); checks++;
    if (w_obs !== '0 || hazard_o !== 1'b0 || w_obs !== exp_obs) begin
      failures++; $display("FAIL reset_mid_stall got obs=%h hz=%b exp all 0", w_obs, hazard_o);
    end
    stall_i = 1'b0; rst_i = 1'b0;
    cycle();
    exp_obs = sb.pop_front(); checks++;
    if (w_obs !== exp_obs || valid_o !== 1'b1 || RSaddr_o !== 5'd11) begin
      failures++; $display("FAIL reset_first_load got v=%b rs=%0d exp v=1 rs=11", valid_o, RSaddr_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst_i   = ($urandom_range(0, 49) == 0);
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 6) == 0);
      set_instr($urandom_range(0, 4) != 0, 8'($urandom), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom, $urandom);
      WB_RegWrite_i = $urandom_range(0, 1) == 1;
      WB_RegAddr_i  = 5'($urandom_range(0, 7));
      WB_data_i     = $urandom;
      #1;
      checks++;
      if (hazard_o !== m_hazard() || !w_sat_same) begin
        failures++; $display("FAIL random_hazard[%0d] got=%b exp=%b same=%b", i, hazard_o, m_hazard(), w_sat_same);
      end
      cycle();
      exp_obs = sb.pop_front(); checks++;
      if (w_obs !== exp_obs) begin
        failures++; $display("FAIL random_obs[%0d] got=%h exp=%h", i, w_obs, exp_obs);
      end
    end
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; WB_RegWrite_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; WB_RegWrite_i = 1'b0;
    WB_RegAddr_i = 5'd0; WB_data_i = 32'h0;
    set_instr(1'b0, 8'h00, 5'd0, 5'd0, 32'h0, 32'h0);
    m_bubble(); m_cnt = '0; m_cnt2 = '0;
    test_reset();
    test_load();
    test_bypass();
    test_load_use();
    test_stall_flush();
    test_hazard_stall();
    test_flush_hazard();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
